// File: rtl/comp_tracker_pkg.sv
// Shared types and helpers for the component tracker vector-accumulator sequencer.
package comp_tracker_pkg;

  // Ceiling log2, never less than 1 so a derived index is always at least one bit wide.
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  localparam int unsigned DEF_SERIAL_ACC_LEN_BITS = 7;
  localparam int unsigned DEF_N_ANTS              = 32;
  localparam int unsigned SERIAL_ACC_LEN          = 32'd1 << DEF_SERIAL_ACC_LEN_BITS;
  localparam int unsigned ANT_BITS                = log2c(DEF_N_ANTS);

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter; i_clr makes the current count read as zero for this cycle.
module wrap_counter #(
  parameter int unsigned W   = 1,
  parameter int unsigned MAX = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cur;
  logic [W-1:0] w_cnt_d;

  always_comb begin
    w_cur   = i_clr ? '0 : r_cnt;
    o_wrap  = i_en && (w_cur == W'(MAX));
    w_cnt_d = w_cur;
    if (i_en) begin
      w_cnt_d = o_wrap ? '0 : w_cur + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/comp_vacc_ctrl.sv
// Sequencer for the double-buffered component vector accumulator: antenna/pass tracking,
// clear/last strobes, buffer flipping and sync alignment checking.
module comp_vacc_ctrl
  import comp_tracker_pkg::*;
#(
  parameter  int unsigned SERIAL_ACC_LEN_BITS = DEF_SERIAL_ACC_LEN_BITS,
  parameter  int unsigned N_ANTS              = DEF_N_ANTS,
  localparam int unsigned ANT_BITS_L          = log2c(N_ANTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sync,
  input  logic                  i_en,
  output logic [ANT_BITS_L-1:0] o_ant_idx,
  output logic                  o_acc_clr,
  output logic                  o_acc_last,
  output logic                  o_acc_vld,
  output logic                  o_wr_buf,
  output logic                  o_buf_swap,
  output logic                  o_rd_ready,
  output logic                  o_sync_err
);

  localparam int unsigned PB       = SERIAL_ACC_LEN_BITS;
  localparam int unsigned PASS_MAX = (32'd1 << PB) - 1;

  state_e                  r_state, w_state_d;
  logic [ANT_BITS_L-1:0]   w_ant_cnt, w_ant_eff;
  logic [PB-1:0]           w_pass_cnt, w_pass_eff;
  logic                    w_ant_wrap, w_win_end;
  logic                    w_run, w_cnt_en, w_at_end, w_zero, w_misalign, w_clr;

  logic [ANT_BITS_L-1:0]   r_ant_idx;
  logic                    r_acc_clr, r_acc_last, r_acc_vld;
  logic                    r_wr_buf, r_buf_swap, r_rd_ready, r_sync_err;

  always_comb begin
    w_run    = (r_state == StRun);
    w_cnt_en = i_en && (w_run || i_sync);
    w_at_end = (w_ant_cnt == ANT_BITS_L'(N_ANTS - 1)) && (w_pass_cnt == PB'(PASS_MAX));
    w_zero   = (w_ant_cnt == '0) && (w_pass_cnt == '0);
    // A sync on the final sample of a window lands on the natural wrap, so it is aligned.
    w_misalign = w_run && i_sync && !w_zero && !(i_en && w_at_end);
    w_clr      = i_sync && (!w_run || w_misalign);
    w_ant_eff  = w_clr ? '0 : w_ant_cnt;
    w_pass_eff = w_clr ? '0 : w_pass_cnt;
  end

  wrap_counter #(
    .W   (ANT_BITS_L),
    .MAX (N_ANTS - 1)
  ) u_ant_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_cnt_en),
    .i_clr  (w_clr),
    .o_cnt  (w_ant_cnt),
    .o_wrap (w_ant_wrap)
  );

  // The pass counter wraps exactly on the last sample of a window.
  wrap_counter #(
    .W   (PB),
    .MAX (PASS_MAX)
  ) u_pass_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_ant_wrap),
    .i_clr  (w_clr),
    .o_cnt  (w_pass_cnt),
    .o_wrap (w_win_end)
  );

  always_comb begin
    w_state_d = r_state;
    if (r_state == StIdle && i_sync) begin
      w_state_d = StRun;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_ant_idx  <= '0;
      r_acc_clr  <= 1'b0;
      r_acc_last <= 1'b0;
      r_acc_vld  <= 1'b0;
      r_wr_buf   <= 1'b0;
      r_buf_swap <= 1'b0;
      r_rd_ready <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_acc_vld  <= w_cnt_en;
      r_ant_idx  <= w_cnt_en ? w_ant_eff : '0;
      r_acc_clr  <= w_cnt_en && (w_pass_eff == '0);
      r_acc_last <= w_cnt_en && (w_pass_eff == PB'(PASS_MAX));
      r_buf_swap <= w_win_end;
      r_wr_buf   <= r_wr_buf ^ w_win_end;
      if (w_win_end) begin
        r_rd_ready <= 1'b1;
      end else if (w_misalign) begin
        r_rd_ready <= 1'b0;
      end
      r_sync_err <= r_sync_err | w_misalign;
    end
  end

  assign o_ant_idx  = r_ant_idx;
  assign o_acc_clr  = r_acc_clr;
  assign o_acc_last = r_acc_last;
  assign o_acc_vld  = r_acc_vld;
  assign o_wr_buf   = r_wr_buf;
  assign o_buf_swap = r_buf_swap;
  assign o_rd_ready = r_rd_ready;
  assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_comp_vacc_ctrl.sv
// Directed table-driven bench for comp_vacc_ctrl with N_ANTS=4, SERIAL_ACC_LEN_BITS=2.
module tb_comp_vacc_ctrl;

  localparam int unsigned NA = 4;
  localparam int unsigned SB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic       en = 1'b0;
  logic [1:0] ant_idx;
  logic       acc_clr, acc_last, acc_vld, wr_buf, buf_swap, rd_ready, sync_err;

  always #5 clk = ~clk;

  comp_vacc_ctrl #(
    .SERIAL_ACC_LEN_BITS (SB),
    .N_ANTS              (NA)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sync     (sync),
    .i_en       (en),
    .o_ant_idx  (ant_idx),
    .o_acc_clr  (acc_clr),
    .o_acc_last (acc_last),
    .o_acc_vld  (acc_vld),
    .o_wr_buf   (wr_buf),
    .o_buf_swap (buf_swap),
    .o_rd_ready (rd_ready),
    .o_sync_err (sync_err)
  );

  typedef struct packed {
    logic       rst;
    logic       sync;
    logic       en;
    logic       vld;
    logic [1:0] ant;
    logic       clr;
    logic       last;
    logic       wr;
    logic       swap;
    logic       rdy;
    logic       err;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   swap_cnt = 0;
  logic e_wr = 1'b0, e_rdy = 1'b0, e_err = 1'b0;

  always @(posedge clk) if (buf_swap) swap_cnt++;

  task automatic push(input logic r, input logic s, input logic e, input logic v,
                      input logic [1:0] a, input logic c, input logic l, input logic sw);
    vec_t t;
    t.rst = r; t.sync = s; t.en = e; t.vld = v; t.ant = a; t.clr = c; t.last = l;
    t.swap = sw; t.wr = e_wr; t.rdy = e_rdy; t.err = e_err;
    vq.push_back(t);
  endtask

  // Sample n of a 16-sample window: ant = n%4, pass = n/4; last sample flips the buffer.
  task automatic samp(input int n, input logic s);
    if (n == 15) begin
      e_wr  = ~e_wr;
      e_rdy = 1'b1;
    end
    push(1'b0, s, 1'b1, 1'b1, 2'(n % 4), n < 4, n >= 12, n == 15);
  endtask

  task automatic gap();
    push(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t exp_v;
    logic [8:0] act, exp;

    // Reset, then en with no prior sync must be ignored.
    repeat (2) push(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) push(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    // Window 1: sync alone, then 16 back-to-back samples.
    push(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 16; n++) samp(n, 1'b0);
    gap();
    // Window 2: en on alternate cycles.
    for (int n = 0; n < 16; n++) begin
      samp(n, 1'b0);
      gap();
    end
    // Window 3: sync lands on the final sample (aligned).
    for (int n = 0; n < 16; n++) samp(n, n == 15);
    // Window 4: aligned sync on sample 0, misaligned sync on sample 6.
    samp(0, 1'b1);
    for (int n = 1; n < 6; n++) samp(n, 1'b0);
    e_err = 1'b1;
    e_rdy = 1'b0;
    samp(0, 1'b1);
    for (int n = 1; n < 16; n++) samp(n, 1'b0);
    gap();
    // Window 5: reset at sample 9, en ignored until the next sync.
    for (int n = 0; n < 9; n++) samp(n, 1'b0);
    e_wr = 1'b0; e_rdy = 1'b0; e_err = 1'b0;
    push(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) push(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    samp(0, 1'b1);
    samp(1, 1'b0);
    gap();

    for (int i = 0; i < vq.size(); i++) begin
      exp_v = vq[i];
      rst  = exp_v.rst;
      sync = exp_v.sync;
      en   = exp_v.en;
      @(posedge clk);
      #1;
      act = {acc_vld, ant_idx, acc_clr, acc_last, wr_buf, buf_swap, rd_ready, sync_err};
      exp = {exp_v.vld, exp_v.ant, exp_v.clr, exp_v.last, exp_v.wr, exp_v.swap, exp_v.rdy,
             exp_v.err};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL vec[%0d] {vld,ant,clr,last,wr,swap,rdy,err}: got %b expected %b",
                 i, act, exp);
      end
    end

    // Four complete windows: W1, W2, W3 and the window restarted by the misaligned sync.
    n_checks++;
    if (swap_cnt != 4) begin
      n_fail++;
      $display("FAIL swap_count: got %0d expected 4", swap_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
